// File: rtl/adder_fault_locator_pkg.sv
// Shared constants for the adder fault locator: FSM encoding and combo layout.
package adder_fault_locator_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Bit positions inside the 3-bit combination code
    localparam int unsigned COMBO_A = 0;
    localparam int unsigned COMBO_B = 1;
    localparam int unsigned COMBO_C = 2;

    localparam int unsigned COMBOS_PER_SLICE = 8;

endpackage

// File: rtl/afl_vector_gen.sv
// Maps (slice, combo) to adder operands and the golden sum.
// Bits below the target slice form a propagate chain (a=1, b=0), so the
// carry-in reaches the target slice unchanged; bits above it are zero so the
// target slice's carry-out shows up at sum[slice+1].
module afl_vector_gen
    import adder_fault_locator_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [$clog2(WIDTH)-1:0] slice,
    input  logic [2:0]               combo,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic                     cin,
    output logic [WIDTH:0]           exp_sum
);

    // Build the operand pattern bit by bit and form the full-width golden sum
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i < int'(slice)) begin
                a[i] = 1'b1;
            end else if (i == int'(slice)) begin
                a[i] = combo[COMBO_A];
                b[i] = combo[COMBO_B];
            end
        end
        cin     = combo[COMBO_C];
        exp_sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    end

endmodule

// File: rtl/adder_fault_locator.sv
// Self-test sequencer for a ripple-carry adder: walks every slice through all
// eight full-adder input combinations and records which slices misbehave.
module adder_fault_locator
    import adder_fault_locator_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic [WIDTH-1:0]              a_out,
    output logic [WIDTH-1:0]              b_out,
    output logic                          cin_out,
    input  logic [WIDTH:0]                sum_in,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [WIDTH-1:0]              fail_mask,
    output logic [$clog2(WIDTH)-1:0]      first_fail_slice,
    output logic [2:0]                    first_fail_combo,
    output logic [$clog2(WIDTH*8):0]      mismatch_count
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH*8) + 1;

    logic [2:0]       state_q, state_d;
    logic [SW-1:0]    slice_q, slice_d;
    logic [2:0]       combo_q, combo_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH:0]   exp_q, exp_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [SW-1:0]    ffs_q, ffs_d;
    logic [2:0]       ffc_q, ffc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [SW-1:0]    next_slice, gen_slice;
    logic [2:0]       next_combo, gen_combo;
    logic [WIDTH-1:0] gen_a, gen_b;
    logic             gen_cin;
    logic [WIDTH:0]   gen_exp;
    logic             last_vec, mismatch;

    // Vector index after the current one; from IDLE the first vector is loaded
    always_comb begin
        next_combo = combo_q + 3'd1;
        next_slice = (combo_q == 3'(COMBOS_PER_SLICE - 1)) ? slice_q + SW'(1) : slice_q;
        gen_slice  = (state_q == ST_IDLE) ? '0 : next_slice;
        gen_combo  = (state_q == ST_IDLE) ? '0 : next_combo;
        last_vec   = (slice_q == SW'(WIDTH - 1)) && (combo_q == 3'(COMBOS_PER_SLICE - 1));
        mismatch   = (sum_in != exp_q);
    end

    afl_vector_gen #(
        .WIDTH (WIDTH)
    ) u_vector_gen (
        .slice   (gen_slice),
        .combo   (gen_combo),
        .a       (gen_a),
        .b       (gen_b),
        .cin     (gen_cin),
        .exp_sum (gen_exp)
    );

    // Next-state logic for the FSM, operand registers and result registers
    always_comb begin
        state_d  = state_q;
        slice_d  = slice_q;
        combo_d  = combo_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        exp_d    = exp_q;
        pass_d   = pass_q;
        mask_d   = mask_q;
        ffs_d    = ffs_q;
        ffc_d    = ffc_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    slice_d = '0;
                    combo_d = '0;
                    a_d     = gen_a;
                    b_d     = gen_b;
                    cin_d   = gen_cin;
                    exp_d   = gen_exp;
                    pass_d  = 1'b0;
                    mask_d  = '0;
                    ffs_d   = '0;
                    ffc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_APPLY, ST_SETTLE, ST_CHECK: begin
                if (abort) begin
                    // Partial mask/count survive an abort for post-mortem
                    state_d = ST_IDLE;
                    a_d     = '0;
                    b_d     = '0;
                    cin_d   = 1'b0;
                    pass_d  = 1'b0;
                end else if (state_q == ST_APPLY) begin
                    settle_d = 4'(SETTLE_CYCLES);
                    state_d  = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end else if (state_q == ST_SETTLE) begin
                    settle_d = settle_q - 4'd1;
                    if (settle_q <= 4'd1) begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    if (mismatch) begin
                        cnt_d           = cnt_q + CW'(1);
                        mask_d[slice_q] = 1'b1;
                        if (cnt_q == '0) begin
                            ffs_d = slice_q;
                            ffc_d = combo_q;
                        end
                    end
                    if (last_vec) begin
                        state_d = ST_DONE;
                        a_d     = '0;
                        b_d     = '0;
                        cin_d   = 1'b0;
                        pass_d  = !mismatch && (cnt_q == '0);
                    end else begin
                        state_d = ST_APPLY;
                        slice_d = next_slice;
                        combo_d = next_combo;
                        a_d     = gen_a;
                        b_d     = gen_b;
                        cin_d   = gen_cin;
                        exp_d   = gen_exp;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            slice_q  <= '0;
            combo_q  <= '0;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            exp_q    <= '0;
            pass_q   <= 1'b0;
            mask_q   <= '0;
            ffs_q    <= '0;
            ffc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            slice_q  <= slice_d;
            combo_q  <= combo_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            exp_q    <= exp_d;
            pass_q   <= pass_d;
            mask_q   <= mask_d;
            ffs_q    <= ffs_d;
            ffc_q    <= ffc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status decode and output wiring
    always_comb begin
        busy             = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                           (state_q == ST_CHECK);
        done             = (state_q == ST_DONE);
        a_out            = a_q;
        b_out            = b_q;
        cin_out          = cin_q;
        pass             = pass_q;
        fail_mask        = mask_q;
        first_fail_slice = ffs_q;
        first_fail_combo = ffc_q;
        mismatch_count   = cnt_q;
    end

endmodule

// File: tb/tb_adder_fault_locator.sv
// Bench for adder_fault_locator: two instances (default settle and zero settle)
// driving a behavioural adder with a configurable per-slice carry fault.
module tb_adder_fault_locator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start = 1'b0, abort = 1'b0, start0 = 1'b0, abort0 = 1'b0;
    logic [W-1:0] a_out, b_out, a0, b0, mask, mask0;
    logic cin_out, cin0, busy, busy0, done, done0, pass, pass0;
    logic [W:0] sum_in, sum0;
    logic [2:0] ffs, ffs0, ffc, ffc0;
    logic [6:0] cnt, cnt0;

    bit          fault_en = 1'b0;
    int          fault_slice = 0;
    logic [7:0]  fault_mask = 8'h00;

    int checks = 0;
    int errors = 0;
    bit vec_chk = 1'b0;

    adder_fault_locator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .sum_in(sum_in),
        .busy(busy), .done(done), .pass(pass), .fail_mask(mask),
        .first_fail_slice(ffs), .first_fail_combo(ffc), .mismatch_count(cnt)
    );

    adder_fault_locator #(.WIDTH(W), .SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a_out(a0), .b_out(b0), .cin_out(cin0), .sum_in(sum0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0),
        .first_fail_slice(ffs0), .first_fail_combo(ffc0), .mismatch_count(cnt0)
    );

    // Adder under test: ripple chain whose slice fs inverts its carry-out for
    // every local input combination {cin,b,a} flagged in fm.
    function automatic logic [W:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c_in, input bit en, input int fs,
                                               input logic [7:0] fm);
        logic [W:0] s;
        logic c, co;
        s = '0;
        c = c_in;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            co   = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            if (en && i == fs && fm[{c, b[i], a[i]}]) co = ~co;
            c = co;
        end
        s[W] = c;
        return s;
    endfunction

    always_comb sum_in = adder_model(a_out, b_out, cin_out, fault_en, fault_slice, fault_mask);
    always_comb sum0   = adder_model(a0, b0, cin0, fault_en, fault_slice, fault_mask);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input bit sel, input string tag);
        if (!sel) begin
            check({tag, "_ctl"}, 32'({a_out, b_out, cin_out, busy, done, pass}), 32'd0);
            check({tag, "_res"}, 32'({mask, ffs, ffc, cnt}), 32'd0);
        end else begin
            check({tag, "_ctl0"}, 32'({a0, b0, cin0, busy0, done0, pass0}), 32'd0);
            check({tag, "_res0"}, 32'({mask0, ffs0, ffc0, cnt0}), 32'd0);
        end
    endtask

    task automatic check_results(input bit sel, input string tag, input bit e_pass,
                                 input logic [7:0] e_mask, input int e_ffs, input int e_ffc,
                                 input int e_cnt);
        check({tag, "_pass"}, 32'(sel ? pass0 : pass), 32'(e_pass));
        check({tag, "_mask"}, 32'(sel ? mask0 : mask), 32'(e_mask));
        check({tag, "_ffs"},  32'(sel ? ffs0 : ffs), 32'(e_ffs));
        check({tag, "_ffc"},  32'(sel ? ffc0 : ffc), 32'(e_ffc));
        check({tag, "_cnt"},  32'(sel ? cnt0 : cnt), 32'(e_cnt));
    endtask

    // Reference: apply the first nvec vectors of the exhaustive set to the
    // faulty adder and compare each against exact arithmetic.
    task automatic ref_model(input int nvec, output logic [7:0] m, output int c,
                             output int fs, output int fc);
        logic [W-1:0] a, b;
        logic [W:0] good, got;
        int j, k;
        m = '0; c = 0; fs = 0; fc = 0;
        for (int v = 0; v < nvec; v++) begin
            j = v / 8;
            k = v % 8;
            a = W'((1 << j) - 1) | W'((k & 1) << j);
            b = W'(((k >> 1) & 1) << j);
            good = (W+1)'(a) + (W+1)'(b) + (W+1)'(k >> 2);
            got = adder_model(a, b, 1'(k >> 2), fault_en, fault_slice, fault_mask);
            if (got != good) begin
                if (c == 0) begin fs = j; fc = k; end
                c++;
                m[j] = 1'b1;
            end
        end
    endtask

    // Pulse start, then count edges until done; verify latency and a one-cycle pulse
    task automatic run(input bit sel, input int exp_n, input string tag);
        int n;
        n = 0;
        if (sel) start0 = 1'b1; else start = 1'b1;
        tick;
        start = 1'b0;
        start0 = 1'b0;
        while (n < 2000) begin
            tick;
            n++;
            if (vec_chk && !sel && n >= 116 && n <= 119) begin
                check("vec_s3c5_a", 32'(a_out), 32'h0F);
                check("vec_s3c5_b", 32'(b_out), 32'h00);
                check("vec_s3c5_cin", 32'(cin_out), 32'h1);
            end
            if (sel ? done0 : done) break;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_n));
        tick;
        check({tag, "_done_pulse"}, 32'(sel ? done0 : done), 32'd0);
    endtask

    initial begin
        logic [7:0] rm;
        int rc, rfs, rfc;
        bit seen_done;

        // Reset state
        #1;
        check_zero(0, "reset");
        check_zero(1, "reset");
        tick;
        rst_n = 1'b1;
        tick;

        // Fault-free run with default settle, plus the slice 3 combo 5 vector hold
        vec_chk = 1'b1;
        run(0, 256, "good");
        vec_chk = 1'b0;
        check_results(0, "good", 1'b1, 8'h00, 0, 0, 0);
        check("good_ops", 32'({a_out, b_out, cin_out}), 32'd0);

        // Slice 6 carry-out stuck at 0 when a=b=1
        fault_en = 1'b1; fault_slice = 6; fault_mask = 8'h88;
        run(0, 256, "s6stuck");
        check_results(0, "s6stuck", 1'b0, 8'h40, 6, 3, 2);

        // Start re-pulsed while busy, then abort in SETTLE of slice 2
        fault_slice = 1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 1; n <= 65; n++) begin
            tick;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end
        check("abort_pre_busy", 32'(busy), 32'd1);
        check("abort_pre_ops", 32'({a_out, b_out, cin_out}), 32'({8'h03, 8'h00, 1'b0}));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ops", 32'({a_out, b_out, cin_out}), 32'd0);
        ref_model(16, rm, rc, rfs, rfc);
        check_results(0, "abort", 1'b0, rm, rfs, rfc, rc);
        seen_done = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_quiet", 32'(seen_done), 32'd0);

        // Asynchronous reset in the middle of slice 4
        fault_en = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (130) tick;
        check("midrst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_zero(0, "midrst");
        tick;
        rst_n = 1'b1;
        tick;
        run(0, 256, "postrst");
        check_results(0, "postrst", 1'b1, 8'h00, 0, 0, 0);

        // Zero-settle instance
        run(1, 128, "settle0");
        check_results(1, "settle0", 1'b1, 8'h00, 0, 0, 0);

        // Random single-slice carry faults against the reference model
        for (int r = 0; r < 6; r++) begin
            fault_en = 1'b1;
            fault_slice = int'($urandom_range(0, W - 1));
            fault_mask = 8'($urandom_range(0, 255));
            ref_model(64, rm, rc, rfs, rfc);
            if (r == 5) begin
                run(1, 128, "rand0");
                check_results(1, "rand0", rc == 0, rm, rfs, rfc, rc);
            end else begin
                run(0, 256, "rand");
                check_results(0, "rand", rc == 0, rm, rfs, rfc, rc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_fault_locator.md
Name: adder_fault_locator

Overview:
- Self-test sequencer for a WIDTH-bit ripple-carry adder built from per-bit full-adder slices.
- Drives exhaustive per-slice test vectors into the adder under test and compares each returned sum against an internal golden sum.
- Reports which slices failed, plus the first failing slice and its input combination.
- Sits between a test-control host (start/done handshake) and the adder datapath.

Parameters:
- WIDTH, 8, adder operand width (number of slices), 2..32.
- SETTLE_CYCLES, 2, cycles the adder is given to settle before its sum is sampled, 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a test run; honoured only in IDLE.
- abort  input  1  cancels a run in progress.
- a_out  output  WIDTH  operand A to the adder.
- b_out  output  WIDTH  operand B to the adder.
- cin_out  output  1  carry-in to the adder.
- sum_in  input  WIDTH+1  adder result, including carry-out as the MSB.
- busy  output  1  high in APPLY/SETTLE/CHECK.
- done  output  1  one-cycle pulse at the end of a completed run.
- pass  output  1  high when the last completed run had zero mismatches.
- fail_mask  output  WIDTH  bit i set if any vector targeting slice i mismatched.
- first_fail_slice  output  $clog2(WIDTH)  slice index of the first mismatch.
- first_fail_combo  output  3  combination code of the first mismatch.
- mismatch_count  output  $clog2(WIDTH*8)+1  total mismatching vectors.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - All outputs go to 0, including a_out, b_out, cin_out, pass, fail_mask, first_fail_* and mismatch_count.
- Vector set:
  - Slice j in 0..WIDTH-1 is tested with combo k in 0..7, slice-major, k ascending.
  - a_out[j] = k[0]; b_out[j] = k[1].
  - a_out[j-1:0] = all ones; b_out[j-1:0] = 0. This is the propagate chain.
  - cin_out = k[2], so the carry into slice j equals k[2].
  - All bits above j are 0, so sum_in[j+1] observes slice j's carry-out.
- Golden sum: a_out + b_out + cin_out, computed WIDTH+1 bits wide with no truncation.
- FSM:
  - IDLE: on start, clear results, set slice=0 and combo=0, load vector, go to APPLY. start while busy is ignored.
  - APPLY: 1 cycle; load the settle counter with SETTLE_CYCLES. If SETTLE_CYCLES=0, go directly to CHECK; otherwise go to SETTLE.
  - SETTLE: decrement the counter; go to CHECK when it reaches 0.
  - CHECK: compare sum_in with the golden sum.
    - On mismatch: increment mismatch_count and set fail_mask[slice].
    - If it is the first mismatch of the run: latch slice and combo into first_fail_slice and first_fail_combo.
    - Then advance combo, wrapping 7→0 and incrementing slice.
    - After slice WIDTH-1 combo 7, go to DONE. Otherwise load the next vector and go to APPLY.
  - DONE: done=1 for one cycle; pass = (mismatch_count==0); operands driven to 0; go to IDLE.
- Operand timing:
  - a_out, b_out and cin_out are registered.
  - They update on the edge entering APPLY and hold stable through CHECK.
  - sum_in is sampled only in CHECK.
- Latency: each vector takes SETTLE_CYCLES+2 cycles. With start accepted at edge N, DONE is entered at edge N + WIDTH*8*(SETTLE_CYCLES+2). Defaults give N+256.
- Result visibility: results hold from DONE until the next accepted start.
- first_fail_* with no failures: remain 0 when no mismatch occurred; pass disambiguates.
- abort: in APPLY/SETTLE/CHECK, go to IDLE on the next edge.
  - Operands go to 0, done is not pulsed, pass is forced to 0.
  - Partial fail_mask and mismatch_count are retained.
  - If abort and start arrive together in IDLE, start wins.
- Reset mid-run: immediate return to IDLE with all outputs cleared; no done.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - the combo bit-field positions (A=0, B=1, C=2);
  - the constant COMBOS_PER_SLICE=8.
- One sub-module, afl_vector_gen: purely combinational mapping of (slice, combo) to (a, b, cin, expected sum).
- The FSM, counters and result registers stay in the top module.

Test Plan:
- All-correct 8-bit adder, defaults → done at edge N+256; pass=1, fail_mask=8'h00, mismatch_count=0.
- Slice 6 cout stuck-0 when a=b=1 → pass=0, fail_mask=8'h40, first_fail_slice=6, first_fail_combo=3, mismatch_count=2.
  - Slice 6, combo 7: drives A=8'h7F, B=8'h40, cin=1; expected 9'd192; received 9'd64.
- Vector check, slice 3 combo 5 → A=8'h0F, B=8'h00, cin=1 held for 4 cycles; expected sum 9'h010.
- start re-pulsed while busy, then abort in SETTLE of slice 2 → run not restarted; IDLE next edge; no done; pass=0; operands 0.
- rst_n low mid-run at slice 4 → all outputs 0 asynchronously; new start then gives a full 256-cycle run.
- SETTLE_CYCLES=0 → each vector takes 2 cycles; done at edge N+128; results identical to the first scenario.
